// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the data-memory controller.
//   dmem_state_t  - controller state (IDLE, BUSY, DONE)
//   WORD_BE       - byte-enable pattern for a full-word access
//   is_misaligned - word accesses must sit on a 4-byte boundary
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } dmem_state_t;

    localparam logic [3:0] WORD_BE = 4'b1111;

    function automatic logic is_misaligned(input logic byte_op, input logic [1:0] offset);
        return !byte_op && (offset != 2'b00);
    endfunction

endpackage

// File: rtl/dmem_if.sv
// dmem_if: variable-latency req/ack memory port.
//   mem_req   - request, held until ack or timeout (master -> slave)
//   mem_we    - write enable
//   mem_be    - byte enables
//   mem_addr  - word-aligned address
//   mem_wdata - write data
//   mem_rdata - read data, valid with mem_ack (slave -> master)
//   mem_ack   - one-cycle completion strobe
interface dmem_if;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/dmem_lane.sv
// dmem_lane: combinational byte-lane steering.
//   byte_op    in  - 1 = byte access, 0 = word access
//   offset     in  - byte offset within the word (Addr[1:0])
//   store_data in  - core store data
//   load_raw   in  - raw word returned by memory
//   be         out - byte enables for the bus
//   wdata      out - store data placed on the bus lanes
//   load_data  out - load result, zero-extended for bytes
module dmem_lane
    import dmem_pkg::*;
(
    input  logic        byte_op,
    input  logic [1:0]  offset,
    input  logic [31:0] store_data,
    input  logic [31:0] load_raw,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);

    logic [7:0] load_byte;

    always_comb begin
        load_byte = load_raw[7:0];
        case (offset)
            2'd1:    load_byte = load_raw[15:8];
            2'd2:    load_byte = load_raw[23:16];
            2'd3:    load_byte = load_raw[31:24];
            default: load_byte = load_raw[7:0];
        endcase
    end

    always_comb begin
        if (byte_op) begin
            be        = 4'b0001 << offset;
            // Replicate the byte so it lands on whichever lane is enabled.
            wdata     = {4{store_data[7:0]}};
            load_data = {24'b0, load_byte};
        end else begin
            be        = WORD_BE;
            wdata     = store_data;
            load_data = load_raw;
        end
    end

endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: data-memory controller downstream of the single-cycle datapath.
//   clk        in  - core clock
//   reset      in  - asynchronous active-low reset
//   MemAccess  in  - current instruction is a load or store
//   MemWrite   in  - 1 = store, 0 = load
//   ByteOp     in  - 1 = byte access, 0 = word access
//   Addr       in  - byte address (ALU result)
//   WriteData  in  - store data
//   ReadData   out - registered load data
//   Stall      out - hold PC / suppress RegWrite
//   Fault      out - sticky misalignment / timeout flag
//   mem        - master side of the req/ack memory port
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemAccess,
    input  logic        MemWrite,
    input  logic        ByteOp,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Stall,
    output logic        Fault,
    dmem_if.master      mem
);

    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    dmem_state_t      state;
    logic [CNT_W-1:0] wait_cnt;
    logic             byte_q;
    logic [1:0]       off_q;

    logic        lane_byte;
    logic [1:0]  lane_off;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;
    logic [31:0] lane_load;

    // In IDLE the lane unit steers the incoming request; afterwards it
    // extracts load data using the fields latched at request time.
    assign lane_byte = (state == IDLE) ? ByteOp    : byte_q;
    assign lane_off  = (state == IDLE) ? Addr[1:0] : off_q;

    dmem_lane u_lane (
        .byte_op    (lane_byte),
        .offset     (lane_off),
        .store_data (WriteData),
        .load_raw   (mem.mem_rdata),
        .be         (lane_be),
        .wdata      (lane_wdata),
        .load_data  (lane_load)
    );

    assign Stall = ((state == IDLE) && MemAccess) || (state == BUSY);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            wait_cnt      <= '0;
            byte_q        <= 1'b0;
            off_q         <= 2'b00;
            ReadData      <= '0;
            Fault         <= 1'b0;
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_be    <= '0;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (MemAccess) begin
                        if (is_misaligned(ByteOp, Addr[1:0])) begin
                            state    <= DONE;
                            Fault    <= 1'b1;
                            ReadData <= '0;
                        end else begin
                            state         <= BUSY;
                            mem.mem_req   <= 1'b1;
                            mem.mem_we    <= MemWrite;
                            mem.mem_be    <= lane_be;
                            mem.mem_addr  <= {Addr[31:2], 2'b00};
                            mem.mem_wdata <= lane_wdata;
                            byte_q        <= ByteOp;
                            off_q         <= Addr[1:0];
                            wait_cnt      <= '0;
                        end
                    end
                end
                BUSY: begin
                    // Ack wins over the timeout threshold in the same cycle.
                    if (mem.mem_ack) begin
                        mem.mem_req <= 1'b0;
                        state       <= DONE;
                        if (!mem.mem_we) begin
                            ReadData <= lane_load;
                        end
                    end else if (wait_cnt == CNT_LAST) begin
                        mem.mem_req <= 1'b0;
                        Fault       <= 1'b1;
                        ReadData    <= '0;
                        state       <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: self-checking bench for dmem_ctrl with a memory slave and
// a byte-addressed reference model of memory contents.
module tb_dmem_ctrl;

    localparam int TIMEOUT = 16;
    localparam int NO_ACK  = 99;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemAccess, MemWrite, ByteOp;
    logic [31:0] Addr, WriteData;
    logic [31:0] ReadData;
    logic        Stall, Fault;

    dmem_if bus ();

    dmem_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .reset     (reset),
        .MemAccess (MemAccess),
        .MemWrite  (MemWrite),
        .ByteOp    (ByteOp),
        .Addr      (Addr),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .Stall     (Stall),
        .Fault     (Fault),
        .mem       (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Slave storage (word-addressed) and reference model (byte-addressed).
    logic [31:0] slv_w [bit [31:0]];
    bit   [7:0]  ref_b [bit [31:0]];
    logic [31:0] exp_rd;
    logic        exp_fault;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] dflt(input logic [31:0] wa);
        return wa ^ 32'h5A3C_96E1;
    endfunction

    function automatic logic [31:0] slv_read(input logic [31:0] wa);
        if (slv_w.exists(wa)) return slv_w[wa];
        return dflt(wa);
    endfunction

    function automatic bit [7:0] ref_byte(input logic [31:0] a);
        logic [31:0] w;
        if (ref_b.exists(a)) return ref_b[a];
        w = dflt({a[31:2], 2'b00}) >> (8 * a[1:0]);
        return w[7:0];
    endfunction

    function automatic logic [31:0] ref_load(input bit bop, input logic [31:0] a);
        logic [31:0] wa;
        wa = {a[31:2], 2'b00};
        if (bop) return {24'b0, ref_byte(a)};
        return {ref_byte(wa + 3), ref_byte(wa + 2), ref_byte(wa + 1), ref_byte(wa)};
    endfunction

    task automatic ref_store(input bit bop, input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] wa;
        wa = {a[31:2], 2'b00};
        if (bop) ref_b[a] = wd[7:0];
        else for (int i = 0; i < 4; i++) ref_b[wa + i] = wd[8*i +: 8];
    endtask

    task automatic preload(input logic [31:0] wa, input logic [31:0] val);
        slv_w[wa] = val;
        for (int i = 0; i < 4; i++) ref_b[wa + i] = val[8*i +: 8];
    endtask

    // Slave response for the current bus request.
    task automatic slave_ack();
        logic [31:0] w;
        w = slv_read(bus.mem_addr);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = w;
        if (bus.mem_we) begin
            for (int i = 0; i < 4; i++)
                if (bus.mem_be[i]) w[8*i +: 8] = bus.mem_wdata[8*i +: 8];
            slv_w[bus.mem_addr] = w;
        end
    endtask

    // One complete access; called and returns at a negedge with state IDLE.
    // lat = number of BUSY cycles before the ack cycle (>= TIMEOUT means no ack).
    task automatic access(input bit we, input bit bop, input logic [31:0] a,
                          input logic [31:0] wd, input int lat);
        bit          mis;
        logic [31:0] e_addr, e_wd, e_load;
        logic [3:0]  e_be;
        int          req_cyc, stall_n, e_req;
        bit          stable;
        mis    = !bop && (a[1:0] != 2'b00);
        e_addr = {a[31:2], 2'b00};
        e_be   = bop ? (4'b0001 << a[1:0]) : 4'b1111;
        e_wd   = bop ? {4{wd[7:0]}} : wd;
        e_load = ref_load(bop, a);

        MemAccess = 1'b1; MemWrite = we; ByteOp = bop; Addr = a; WriteData = wd;
        stall_n = 0;
        #1;
        if (Stall === 1'b1) stall_n++;
        @(posedge clk); @(negedge clk);
        req_cyc = 0;
        stable  = 1'b1;
        if (!mis) begin
            chk("req_addr",  bus.mem_addr,  e_addr);
            chk("req_be",    {28'b0, bus.mem_be}, {28'b0, e_be});
            chk("req_wdata", bus.mem_wdata, e_wd);
            chk("req_we",    {31'b0, bus.mem_we}, {31'b0, we});
        end
        while (bus.mem_req === 1'b1 && req_cyc < TIMEOUT + 4) begin
            if (Stall === 1'b1) stall_n++;
            if (bus.mem_addr !== e_addr || bus.mem_be !== e_be ||
                bus.mem_wdata !== e_wd || bus.mem_we !== we) stable = 1'b0;
            if (req_cyc == lat) slave_ack();
            req_cyc++;
            @(posedge clk); @(negedge clk);
            bus.mem_ack   = 1'b0;
            bus.mem_rdata = $urandom;
        end

        e_req = mis ? 0 : ((lat < TIMEOUT) ? lat + 1 : TIMEOUT);
        if (mis || lat >= TIMEOUT) begin
            exp_rd    = '0;
            exp_fault = 1'b1;
        end else if (!we) begin
            exp_rd = e_load;
        end else begin
            ref_store(bop, a, wd);
        end
        chk("req_cycles",   req_cyc, e_req);
        chk("stall_cycles", stall_n, e_req + 1);
        chk("fields_held",  {31'b0, stable}, 32'd1);
        chk("done_stall",   {31'b0, Stall}, 32'd0);
        chk("done_rdata",   ReadData, exp_rd);
        chk("done_fault",   {31'b0, Fault}, {31'b0, exp_fault});
        // MemAccess is still high in DONE and must be ignored.
        @(posedge clk); @(negedge clk);
        chk("idle_req", {31'b0, bus.mem_req}, 32'd0);
        MemAccess = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit          we, bop;
        logic [31:0] a;
        int          r, lat;

        reset = 1'b0;
        MemAccess = 1'b0; MemWrite = 1'b0; ByteOp = 1'b0;
        Addr = '0; WriteData = '0;
        bus.mem_ack = 1'b0; bus.mem_rdata = '0;
        exp_rd = '0; exp_fault = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_rdata", ReadData, 32'd0);
        chk("rst_fault", {31'b0, Fault}, 32'd0);
        chk("rst_req",   {31'b0, bus.mem_req}, 32'd0);
        chk("rst_we",    {31'b0, bus.mem_we}, 32'd0);
        chk("rst_be",    {28'b0, bus.mem_be}, 32'd0);
        chk("rst_addr",  bus.mem_addr, 32'd0);
        chk("rst_wdata", bus.mem_wdata, 32'd0);
        chk("rst_stall", {31'b0, Stall}, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Directed cases.
        preload(32'h100, 32'hDEADBEEF);
        access(1'b0, 1'b0, 32'h100, 32'h0, 1);
        access(1'b1, 1'b1, 32'h203, 32'h12345678, 0);
        access(1'b0, 1'b0, 32'h200, 32'h0, 2);
        preload(32'h40, 32'hAABBCCDD);
        access(1'b0, 1'b1, 32'h42, 32'h0, 0);
        access(1'b0, 1'b0, 32'h40, 32'h0, TIMEOUT - 1);
        access(1'b0, 1'b0, 32'h101, 32'h0, 0);
        access(1'b0, 1'b0, 32'h300, 32'h0, NO_ACK);
        access(1'b1, 1'b0, 32'h300, 32'hCAFEF00D, 0);
        access(1'b0, 1'b0, 32'h300, 32'h0, 3);

        // Randomized accesses against the reference model.
        for (int n = 0; n < 40; n++) begin
            we  = 1'($urandom_range(0, 1));
            bop = 1'($urandom_range(0, 1));
            a   = 32'h1000 + 32'($urandom_range(0, 15) << 2) + 32'($urandom_range(0, 3));
            if (!bop && $urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            r   = $urandom_range(0, 9);
            lat = (r == 9) ? NO_ACK : (r % 4);
            access(we, bop, a, $urandom, lat);
        end

        // Reset in the middle of BUSY, then a stray late ack.
        MemAccess = 1'b1; MemWrite = 1'b0; ByteOp = 1'b0;
        Addr = 32'h80; WriteData = '0;
        @(posedge clk); @(negedge clk);
        chk("busy_req", {31'b0, bus.mem_req}, 32'd1);
        #2 reset = 1'b0;
        #1 chk("async_req_drop", {31'b0, bus.mem_req}, 32'd0);
        MemAccess = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        exp_rd = '0; exp_fault = 1'b0;
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'hFFFFFFFF;
        @(posedge clk); @(negedge clk);
        bus.mem_ack = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("late_ack_rdata", ReadData, 32'd0);
        chk("late_ack_fault", {31'b0, Fault}, 32'd0);
        chk("late_ack_req",   {31'b0, bus.mem_req}, 32'd0);
        chk("late_ack_stall", {31'b0, Stall}, 32'd0);
        access(1'b0, 1'b0, 32'h300, 32'h0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Data-memory controller sitting directly downstream of the single-cycle datapath. It consumes the datapath's ALU result (address) and store data, and returns load data for the result mux. It drives a variable-latency req/ack memory port, stalls the core while an access is outstanding, and handles byte/word lane steering. Misaligned accesses and bus timeouts raise a fault.

## Interface
Parameters:
- TIMEOUT, 16: maximum BUSY cycles waited for mem_ack before faulting; must be ≥ 2.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low; low forces reset state immediately.
- MemAccess  in  1  current instruction is a load or store.
- MemWrite  in  1  1 = store, 0 = load; valid with MemAccess.
- ByteOp  in  1  1 = byte access (LDRB/STRB), 0 = word.
- Addr  in  32  byte address (datapath ALUResult).
- WriteData  in  32  store data; byte stores use bits [7:0].
- ReadData  out  32  registered load data, zero-extended for bytes.
- Stall  out  1  hold PC and suppress RegWrite this cycle.
- Fault  out  1  sticky error flag.
- mem_req  out  1  memory request, held until ack or timeout.
- mem_we  out  1  write enable.
- mem_be  out  4  byte enables.
- mem_addr  out  32  word-aligned address, {Addr[31:2],2'b00}.
- mem_wdata  out  32  write data.
- mem_rdata  in  32  read data; valid when mem_ack=1.
- mem_ack  in  1  one-cycle completion strobe.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE → BUSY when MemAccess=1 and the access is aligned. On that edge, latch mem_we, mem_be, mem_addr, mem_wdata and ByteOp/Addr[1:0], and clear the wait counter.
- IDLE → DONE when MemAccess=1 and the access is misaligned (ByteOp=0 and Addr[1:0]≠0). No request is issued, Fault sets, and ReadData loads 0.
- BUSY: mem_req=1 and the latched request fields are held stable.
  - mem_ack=1: capture steered mem_rdata into ReadData (loads only; stores leave ReadData unchanged) and go to DONE.
  - No ack: increment the counter. When the counter reaches TIMEOUT−1 without ack, set Fault, set ReadData=0, and go to DONE.
- DONE: unconditionally → IDLE. The instruction retires this cycle, and MemAccess is ignored here.
- Lane steering:
  - Word access: mem_be=4'b1111 and mem_wdata=WriteData.
  - Byte access: mem_be=4'b0001<<Addr[1:0] and mem_wdata={4{WriteData[7:0]}}. Load returns {24'b0, mem_rdata[8*Addr[1:0]+:8]}.
- Fault is sticky and cleared only by reset. After a fault, accesses continue normally.
- mem_ack outside BUSY is ignored.

## Timing
- Reset values: state=IDLE, ReadData=0, Fault=0, mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0.
- Stall is combinational: Stall = (IDLE & MemAccess) | BUSY. It is 0 in DONE.
- Minimum access takes 3 cycles: IDLE (request seen), BUSY (ack in the same cycle), DONE (ReadData valid, Stall=0).
- Each extra cycle of ack latency adds one BUSY cycle. Timeout is exactly TIMEOUT BUSY cycles.
- A misaligned access takes 2 cycles: IDLE, then DONE.
- Back-to-back accesses: after DONE, the next instruction's MemAccess in IDLE starts a new access. There is no overlap.
- An ack arriving in the same cycle as the timeout threshold counts as success; Fault stays clear.
- Reset asserted mid-BUSY drops mem_req asynchronously. Any later ack is ignored.
- All other outputs are registered.

## Structure
- Package dmem_pkg holds:
  - typedef enum logic [1:0] {IDLE, BUSY, DONE} dmem_state_t;
  - the constant WORD_BE = 4'b1111.
- Sub-module dmem_lane (combinational) does byte-enable generation, store replication and load extraction/zero-extension. It is instantiated once.
- The timeout counter is sized $clog2(TIMEOUT) bits and lives inline.

## Test plan
- Word load, Addr=0x100, mem_ack one cycle after mem_req, mem_rdata=0xDEADBEEF → mem_addr=0x100, mem_be=1111, Stall high 3 cycles (IDLE, BUSY×2), ReadData=0xDEADBEEF in DONE, Fault=0.
- Byte store, Addr=0x203, WriteData=0x12345678, immediate ack → mem_be=1000, mem_wdata=0x78787878, mem_addr=0x200, mem_we=1.
- Byte load, Addr=0x42, mem_rdata=0xAABBCCDD → ReadData=0x000000BB.
- Misaligned word load, Addr=0x101 → mem_req never asserted, Fault=1, ReadData=0, Stall high for exactly 1 cycle.
- No ack with TIMEOUT=16 → mem_req high exactly 16 cycles, then DONE with Fault=1 and ReadData=0. A subsequent aligned access succeeds and Fault stays 1.
- reset driven low during BUSY → mem_req falls without a clock edge. A late ack after reset release causes no state change, and ReadData stays 0.
